// File: rtl/boot_loader.sv
// UART boot loader: holds the core in reset, receives a framed program image
// (A5, N_lo, N_hi, 4*N payload bytes, XOR checksum) over an 8N1 serial line,
// writes it word by word into BlockRAM, then releases cu_rst on a good checksum.
module boot_loader #(
    parameter int CLKS_PER_BIT  = 868,
    parameter int D_WIDTH       = 32,
    parameter int D_DEPTH_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     uart_rx,
    output logic                     mem_en,
    output logic [3:0]               mem_wr_mask,
    output logic [D_DEPTH_WIDTH-1:0] mem_addr,
    output logic [D_WIDTH-1:0]       mem_data,
    output logic                     cu_rst,
    output logic                     busy,
    output logic                     error,
    output logic [D_DEPTH_WIDTH:0]   words_loaded
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]      N_MAX     = 17'(2 ** D_DEPTH_WIDTH);
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;

    // ------------------------------------------------------------------
    // RX front end
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t        rx_state_q;
    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shreg_q;
    logic             byte_valid_q;
    logic             frame_err_q;
    logic             rx_s;

    assign rx_s = sync_q[1];

    // Synchronise the line, then time start/data/stop samples from the start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q   <= R_IDLE;
            sync_q       <= 2'b11;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], uart_rx};
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (rx_state_q)
                R_IDLE: begin
                    cnt_q     <= '0;
                    bit_idx_q <= '0;
                    if (!rx_s) rx_state_q <= R_START;
                end
                R_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q      <= '0;
                        // a line that is high again at mid start bit was a glitch
                        rx_state_q <= rx_s ? R_IDLE : R_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shreg_q <= {rx_s, shreg_q[7:1]};
                        if (bit_idx_q == 3'd7) rx_state_q <= R_STOP;
                        else                   bit_idx_q  <= bit_idx_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q        <= '0;
                        byte_valid_q <= rx_s;
                        frame_err_q  <= !rx_s;
                        // re-arm mid stop bit so back-to-back bytes are caught
                        rx_state_q   <= R_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= R_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {L_IDLE, L_LEN_LO, L_LEN_HI, L_DATA, L_CSUM, L_DONE, L_ERR} ld_state_t;

    ld_state_t              st_q;
    logic [15:0]            n_q;
    logic [D_DEPTH_WIDTH:0] addr_q;
    logic [23:0]            word_q;
    logic [1:0]             byte_idx_q;
    logic [7:0]             csum_q;
    logic                   mem_en_q;
    logic [D_DEPTH_WIDTH-1:0] mem_addr_q;
    logic [D_WIDTH-1:0]     mem_data_q;
    logic                   cu_rst_q;
    logic                   error_q;
    logic [D_DEPTH_WIDTH:0] wl_q;
    logic                   busy_st;
    logic [16:0]            n_full;

    assign busy_st = (st_q == L_LEN_LO) || (st_q == L_LEN_HI) ||
                     (st_q == L_DATA)   || (st_q == L_CSUM);
    assign n_full  = {1'b0, shreg_q, n_q[7:0]};

    // Frame parsing, word assembly, write strobe and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= L_IDLE;
            n_q        <= '0;
            addr_q     <= '0;
            word_q     <= '0;
            byte_idx_q <= '0;
            csum_q     <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            cu_rst_q   <= 1'b1;
            error_q    <= 1'b0;
            wl_q       <= '0;
        end else begin
            mem_en_q <= 1'b0;
            if (mem_en_q) wl_q <= wl_q + 1'b1;
            if (st_q == L_IDLE) begin
                wl_q       <= '0;
                csum_q     <= '0;
                addr_q     <= '0;
                byte_idx_q <= '0;
            end
            if (frame_err_q && busy_st) begin
                // partial word is simply dropped; nothing was strobed for it
                st_q       <= L_ERR;
                error_q    <= 1'b1;
                cu_rst_q   <= 1'b1;
                byte_idx_q <= '0;
            end else if (byte_valid_q) begin
                case (st_q)
                    L_IDLE: if (shreg_q == SYNC_BYTE) st_q <= L_LEN_LO;
                    L_LEN_LO: begin
                        n_q[7:0] <= shreg_q;
                        st_q     <= L_LEN_HI;
                    end
                    L_LEN_HI: begin
                        n_q[15:8] <= shreg_q;
                        if (n_full > N_MAX) begin
                            st_q    <= L_ERR;
                            error_q <= 1'b1;
                        end else if (n_full == '0) begin
                            st_q <= L_CSUM;
                        end else begin
                            st_q <= L_DATA;
                        end
                    end
                    L_DATA: begin
                        csum_q     <= csum_q ^ shreg_q;
                        byte_idx_q <= byte_idx_q + 1'b1;
                        case (byte_idx_q)
                            2'd0: word_q[7:0]   <= shreg_q;
                            2'd1: word_q[15:8]  <= shreg_q;
                            2'd2: word_q[23:16] <= shreg_q;
                            default: begin
                                mem_en_q   <= 1'b1;
                                mem_addr_q <= addr_q[D_DEPTH_WIDTH-1:0];
                                mem_data_q <= {shreg_q, word_q};
                                addr_q     <= addr_q + 1'b1;
                                if (16'(addr_q) + 16'd1 == n_q) st_q <= L_CSUM;
                            end
                        endcase
                    end
                    L_CSUM: begin
                        if (shreg_q == csum_q) begin
                            st_q     <= L_DONE;
                            cu_rst_q <= 1'b0;
                        end else begin
                            st_q    <= L_ERR;
                            error_q <= 1'b1;
                        end
                    end
                    L_ERR: begin
                        if (shreg_q == SYNC_BYTE) begin
                            st_q       <= L_LEN_LO;
                            error_q    <= 1'b0;
                            addr_q     <= '0;
                            wl_q       <= '0;
                            csum_q     <= '0;
                            byte_idx_q <= '0;
                        end
                    end
                    default: ;  // DONE: only rst leaves
                endcase
            end
        end
    end

    // A reset coinciding with the strobe cancels the write
    assign mem_en       = mem_en_q && !rst;
    assign mem_wr_mask  = {4{mem_en}};
    assign mem_addr     = mem_addr_q;
    assign mem_data     = mem_data_q;
    assign cu_rst       = cu_rst_q;
    assign busy         = busy_st;
    assign error        = error_q;
    assign words_loaded = wl_q;

endmodule

// File: doc/boot_loader.md
# boot_loader

UART boot loader that sits directly upstream of the `System` top level. It holds the core in reset via `cu_rst`, receives a framed program image over a serial line, and writes it word by word into the instruction/data BlockRAM through the memory write port. On a valid checksum it releases `cu_rst` so the control unit starts fetching from address 0.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- `D_WIDTH`, default 32: memory word width; fixed at 32.
- `D_DEPTH_WIDTH`, default 10: memory word-address width (1024 words).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset.
- `uart_rx` in 1: asynchronous serial input; 8N1, LSB first; idles high.
- `mem_en` out 1: one-cycle memory write strobe.
- `mem_wr_mask` out 4: byte write mask; `4'b1111` when `mem_en`=1, else `4'b0000`.
- `mem_addr` out D_DEPTH_WIDTH: word address.
- `mem_data` out D_WIDTH: word to write.
- `cu_rst` out 1: reset to the control unit; high until a load completes.
- `busy` out 1: high while in LEN_LO, LEN_HI, DATA or CSUM.
- `error` out 1: sticky failure flag.
- `words_loaded` out D_DEPTH_WIDTH+1: count of words written in the current frame.

## Operation

- **Reset values:** `mem_en`=0, `mem_wr_mask`=0, `mem_addr`=0, `mem_data`=0, `cu_rst`=1, `busy`=0, `error`=0, `words_loaded`=0. Both FSMs return to IDLE. Reset mid-frame discards the frame.
- **RX front end:**
  - 2-flop synchroniser on `uart_rx`.
  - Start is detected when the synchronised line is low in RX idle.
  - At CLKS_PER_BIT/2 the line is re-sampled. If it is high, this is a false start and RX returns to idle.
  - Data bits are sampled every CLKS_PER_BIT after that, 8 bits LSB first. The stop bit is sampled one bit-time after bit 7.
  - Stop bit = 1: a one-cycle internal `byte_valid` pulse is issued. Stop bit = 0: a one-cycle `frame_err` pulse is issued.
  - RX returns to idle immediately after the stop-bit sample, so back-to-back bytes are accepted.
- **Frame format:** `0xA5`, N_lo, N_hi, then 4·N payload bytes (each word little-endian), then a checksum byte equal to the XOR of all payload bytes. With N=0 the checksum is `0x00`.
- **Loader FSM states:** IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
  - **IDLE:** a `0xA5` byte moves to LEN_LO; any other byte is ignored. Also clears `words_loaded` and the running checksum.
  - **LEN_LO:** latches N[7:0], then moves to LEN_HI.
  - **LEN_HI:** latches N[15:8].
    - N > 2^D_DEPTH_WIDTH → ERR.
    - N = 0 → CSUM.
    - Otherwise → DATA.
  - **DATA:** shifts bytes into `word[8k+7:8k]` for k = 0..3 and XORs each into the checksum. On the 4th byte it writes the word and increments address and `words_loaded`. After word N it moves to CSUM.
  - **CSUM:** if the received byte equals the running XOR → DONE, else → ERR.
  - **DONE:** `cu_rst`=0. All RX traffic is ignored. Only `rst` leaves this state.
  - **ERR:** `error`=1, `cu_rst`=1. A `0xA5` byte clears `error`, resets address, count and checksum, and moves to LEN_LO.
- `frame_err` in any busy state → ERR. Any partially assembled word is discarded and not written. In IDLE, ERR and DONE, `frame_err` is ignored.
- Words are written to addresses 0..N−1 in order. `mem_addr` and `mem_data` hold their last values between strobes.

## Timing

- Line-to-sample latency is 2 cycles (synchroniser).
- `byte_valid` is asserted in the cycle after the stop-bit sample.
- `mem_en` pulses high for exactly 1 cycle, in the cycle after `byte_valid` of a word's 4th byte. `mem_addr`, `mem_data` and `mem_wr_mask` are valid in that same cycle. `words_loaded` increments in the following cycle.
- `cu_rst` falls in the cycle after `byte_valid` of a matching checksum and stays 0 until `rst`.
- `error` rises in the cycle after the failing `byte_valid` or `frame_err`.
- The minimum spacing between `mem_en` pulses is 40·CLKS_PER_BIT cycles, set by the line rate. No backpressure exists; the memory must accept a write on every strobe.
- `rst` asserted in the same cycle as `mem_en` wins: the write is suppressed and all outputs go to their reset values next cycle.

## Test plan

- **Reset** (CLKS_PER_BIT=16): assert `rst` for 3 cycles → `cu_rst`=1, `mem_en`=0, `error`=0, `busy`=0, `words_loaded`=0. Idle-high line for 1000 cycles → no change.
- **Good load:** send `A5 02 00 13 00 00 00 EF BE AD DE 31`.
  - Response: `mem_en` pulses twice, writing addr 0 = `0x00000013` and addr 1 = `0xDEADBEEF`, each with mask `1111`.
  - Then `cu_rst` → 0, `words_loaded`=2, `error`=0.
- **Bad checksum then retry:** same frame with checksum `0x30` → `error`=1, `cu_rst` stays 1. Resend the correct frame → `error` clears at `A5`; final state matches the good-load case.
- **Garbage plus empty image:** send `00 FF 5A A5 00 00 00` → no `mem_en`; `cu_rst` → 0 one cycle after the last byte; `words_loaded`=0.
- **Framing error:** send `A5 01 00 11 22`, then a byte with stop bit 0 → `error`=1, no `mem_en` ever asserted, FSM in ERR, `busy`=0.
- **Oversize and mid-frame reset:**
  - Send `A5 01 04` (N=1025) → `error`=1 after `LEN_HI`, no writes.
  - Separately, assert `rst` after the 2nd payload byte of a valid frame → all outputs at reset values, no write issued.
